gowin_rpll_100mhz: RTL and testbench

GOWIN_RPLL_100MHZ -- requirements
Module: gowin_rpll_100mhz

---
 rtl/gowin_rpll_100mhz.sv | 120 ++++++++++++
 tb/tb_gowin_rpll_100mhz.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/gowin_rpll_100mhz.sv
`timescale 1ns/1ps
// Behavioral rPLL model: measures the clkin period, synthesizes clkout at
// fin*(FBDIV_SEL+1)/(IDIV_SEL+1) and flags lock after LOCK_CYCLES in-tolerance periods.
module gowin_rpll_100mhz #(
  parameter int IDIV_SEL    = 26,
  parameter int FBDIV_SEL   = 99,
  parameter int LOCK_CYCLES = 16,
  parameter int TOL_PPM     = 10000
) (
  input  logic clkin,
  input  logic rst_n,
  output logic clkout,
  output logic lock
);

  bit      clk_q;
  bit      lock_q;
  bit      have_edge;
  bit      have_ref;
  bit      stopping;
  int      stable_cnt;
  int      phase_id;
  int      edge_id;
  realtime tref;
  realtime last_t;

  // Gating by rst_n makes reset take effect in the same instant it falls.
  assign clkout = clk_q & rst_n;
  assign lock   = lock_q & rst_n;

  function automatic realtime half_of(input realtime t);
    return t * real'(IDIV_SEL + 1) / (2.0 * real'(FBDIV_SEL + 1));
  endfunction

  function automatic bit in_tol(input realtime p, input realtime r);
    realtime tol;
    tol = r * real'(TOL_PPM) / 1.0e6;
    return (p >= r - tol) && (p <= r + tol);
  endfunction

  // One generator per phase_id; bumping phase_id retires it before its next toggle.
  task automatic run_clk(input int id, input realtime h);
    while (id == phase_id) begin
      #(h);
      if (id != phase_id) break;
      clk_q = ~clk_q;
      if (stopping && !clk_q) begin
        stopping = 1'b0;
        phase_id = phase_id + 1;
      end
    end
  endtask

  // Fires only if neither a clkin edge nor a reset occurred since it was armed.
  task automatic watchdog(input int id, input realtime w);
    #(w);
    if (id == edge_id) begin
      lock_q     = 1'b0;
      stable_cnt = 0;
      have_edge  = 1'b0;
      have_ref   = 1'b0;
      tref       = 0.0;
      if (clk_q) stopping = 1'b1;
      else       phase_id = phase_id + 1;
    end
  endtask

  always begin : model
    realtime period;
    bit      start_clk;
    @(posedge clkin or negedge rst_n);
    edge_id   = edge_id + 1;
    start_clk = 1'b0;
    if (!rst_n) begin
      clk_q      = 1'b0;
      lock_q     = 1'b0;
      stable_cnt = 0;
      tref       = 0.0;
      have_edge  = 1'b0;
      have_ref   = 1'b0;
      stopping   = 1'b0;
      phase_id   = phase_id + 1;
    end else begin
      if (have_edge) begin
        period = $realtime - last_t;
        if (have_ref && in_tol(period, tref)) begin
          if (stable_cnt < LOCK_CYCLES) stable_cnt = stable_cnt + 1;
          if (stable_cnt >= LOCK_CYCLES) lock_q = 1'b1;
        end else begin
          // First measurement or a frequency jump: adopt this period and restart clkout.
          lock_q     = 1'b0;
          stable_cnt = 0;
          tref       = period;
          have_ref   = 1'b1;
          stopping   = 1'b0;
          phase_id   = phase_id + 1;
          clk_q      = 1'b1;
          start_clk  = 1'b1;
        end
      end
      have_edge = 1'b1;
      last_t    = $realtime;
      if (start_clk) begin
        automatic int      pid = phase_id;
        automatic realtime h   = half_of(tref);
        fork
          run_clk(pid, h);
        join_none
      end
      if (have_ref) begin
        automatic int      eid = edge_id;
        automatic realtime w   = 2.0 * tref;
        fork
          watchdog(eid, w);
        join_none
      end
    end
  end

endmodule

// File: tb/tb_gowin_rpll_100mhz.sv
`timescale 1ns/1ps
// Directed bench for gowin_rpll_100mhz: lock timing, clkout period/duty, reset,
// frequency step, tolerance edges and clock loss.
module tb_gowin_rpll_100mhz;

  logic clkin = 1'b0;
  logic rst_n = 1'b0;
  logic clkout;
  logic lock;

  realtime half_ns    = 18.52;
  bit      clk_run    = 1'b1;
  realtime stretch_ns = 0.0;
  int      stretch_req  = 0;
  int      stretch_done = 0;

  realtime rise_t = 0.0;
  realtime per_w  = 0.0;
  realtime hi_w   = 0.0;
  int      rise_cnt = 0;

  int total = 0;
  int bad   = 0;

  gowin_rpll_100mhz dut (
    .clkin  (clkin),
    .rst_n  (rst_n),
    .clkout (clkout),
    .lock   (lock)
  );

  // A pending stretch lengthens the next low phase, i.e. exactly one clkin period.
  always begin
    #(half_ns);
    if (clk_run) begin
      if (!clkin && stretch_req != stretch_done) begin
        stretch_done = stretch_req;
        #(stretch_ns);
      end
      clkin = ~clkin;
    end
  end

  always @(posedge clkout) begin
    per_w    = $realtime - rise_t;
    rise_t   = $realtime;
    rise_cnt = rise_cnt + 1;
  end

  always @(negedge clkout) hi_w = $realtime - rise_t;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_t(input string tag, input realtime obs, input realtime exp,
                       input realtime tol);
    bit ok;
    total++;
    ok = (obs >= exp - tol) && (obs <= exp + tol);
    assert (ok === 1'b1) else begin
      bad++;
      $error("FAIL %s: observed=%0.4f expected=%0.4f", tag, obs, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clkin);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    bit found;
    int cnt_snap;

    // Reset state
    #10;
    chk("rst_clkout", clkout, 1'b0);
    chk("rst_lock", lock, 1'b0);
    #40 rst_n = 1'b1;

    // E1 (55.56): only a timestamp, clkout still low
    edges(1);
    chk("pre_clkout_e1", clkout, 1'b0);
    // E2 (92.60): reference edge, clkout rises aligned to it
    edges(1);
    chk("start_clkout_e2", clkout, 1'b1);
    chk_t("start_align", rise_t, 92.60, 0.01);
    edges(15);
    chk("lock_low_e17", lock, 1'b0);
    edges(1);
    chk("lock_high_e18", lock, 1'b1);

    #300;
    chk("lock_by_1us", lock, 1'b1);
    chk_t("nom_period", per_w, 10.00, 0.05);
    chk_t("nom_high", hi_w, 5.00, 0.05);

    // Tolerance edges: +0.9% keeps lock, +1.1% drops it
    edges(1);
    stretch_ns = 0.333;
    stretch_req++;
    edges(1);
    chk("tol_0p9_keep", lock, 1'b1);
    edges(1);
    chk("tol_0p9_after", lock, 1'b1);
    stretch_ns = 0.407;
    stretch_req++;
    edges(1);
    chk("tol_1p1_drop", lock, 1'b0);
    edges(20);
    chk("tol_relock", lock, 1'b1);

    // Mid-run reset while clkout is high
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      #0.1;
      found = (clkout === 1'b1);
    end
    chk("mrst_clkout_high", found, 1'b1);
    rst_n = 1'b0;
    #0.001;
    chk("mrst_clkout_0", clkout, 1'b0);
    chk("mrst_lock_0", lock, 1'b0);
    cnt_snap = rise_cnt;
    #20;
    chk_i("mrst_no_toggle", rise_cnt, cnt_snap);
    rst_n = 1'b1;
    edges(17);
    chk("mrst_lock_low_e17", lock, 1'b0);
    edges(1);
    chk("mrst_lock_high_e18", lock, 1'b1);

    // Frequency step to 30 MHz
    half_ns = 16.665;
    edges(1);
    chk("step_lock_drop", lock, 1'b0);
    edges(20);
    chk("step_relock", lock, 1'b1);
    chk_t("step_period", per_w, 9.00, 0.05);
    chk_t("step_high", hi_w, 4.50, 0.05);

    // Clock stop with clkin held low
    @(negedge clkin);
    clk_run = 1'b0;
    #60;
    chk("stop_lock_0", lock, 1'b0);
    chk("stop_clkout_0", clkout, 1'b0);
    cnt_snap = rise_cnt;
    #50;
    chk("stop_clkout_still_0", clkout, 1'b0);
    chk_i("stop_no_toggle", rise_cnt, cnt_snap);

    // Restart and relock
    clk_run = 1'b1;
    edges(17);
    chk("restart_lock_low_e17", lock, 1'b0);
    edges(1);
    chk("restart_lock_high_e18", lock, 1'b1);
    chk_t("restart_period", per_w, 9.00, 0.05);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
